// File: rtl/trng_sampler_if.sv
// rtl/trng_sampler_if.sv - word handshake between trng_sampler and the host logic
interface trng_sampler_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/trng_sampler.sv
// rtl/trng_sampler.sv - ring-oscillator sampler: sync, divided sampling, repetition health test, word packing
// Optional Von Neumann debiasing is enabled by defining VON_NEUMANN_EN.
module trng_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DIV  = 4,
  parameter int WARMUP_CYC  = 16,
  parameter int WORD_W      = 8,
  parameter int REP_LIMIT   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ro_in,
  input  logic           start,
  output logic           ro_activate,
  output logic           busy,
  output logic           fault,
  trng_sampler_if.master dout
);
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int WARM_W = $clog2(WARMUP_CYC + 1);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_COLLECT = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [WARM_W-1:0]      r_warm_cnt;
  logic [DIV_W-1:0]       r_div;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [WORD_W-2:0]      r_shreg;
  logic [WORD_W-1:0]      r_data;
  logic                   r_valid;
  logic                   r_fault;
  logic [REP_W-1:0]       r_rep_cnt;
  logic                   r_last;

  logic                   w_raw;
  logic                   w_strobe;
  logic [REP_W-1:0]       w_rep_next;
  logic                   w_fault_hit;
  logic                   w_accept;
  logic                   w_bit;
  logic                   w_word_done;
  logic [WORD_W-1:0]      w_word;

  assign w_raw    = r_sync[SYNC_STAGES-1];
  assign w_strobe = (r_state == S_COLLECT) && (r_div == DIV_W'(SAMPLE_DIV - 1));

  // rep_cnt==0 marks "no sample yet since warmup", so the first sample always counts as 1
  always_comb begin
    w_rep_next = REP_W'(1);
    if ((r_rep_cnt != '0) && (w_raw == r_last)) begin
      if (r_rep_cnt >= REP_W'(REP_LIMIT)) begin
        w_rep_next = r_rep_cnt;
      end else begin
        w_rep_next = r_rep_cnt + REP_W'(1);
      end
    end
  end

  assign w_fault_hit = w_strobe && (w_rep_next >= REP_W'(REP_LIMIT));

`ifdef VON_NEUMANN_EN
  logic r_pair_have;
  logic r_pair_a;

  assign w_accept = w_strobe && r_pair_have && (r_pair_a != w_raw);
  assign w_bit    = r_pair_a;

  always_ff @(posedge clk) begin
    if (!rst_n || (r_state != S_COLLECT) || (w_next != S_COLLECT)) begin
      r_pair_have <= 1'b0;
      r_pair_a    <= 1'b0;
    end else if (w_strobe) begin
      r_pair_have <= !r_pair_have;
      if (!r_pair_have) begin
        r_pair_a <= w_raw;
      end
    end
  end
`else
  assign w_accept = w_strobe;
  assign w_bit    = w_raw;
`endif

  assign w_word_done = w_accept && (r_bit_cnt == BIT_W'(WORD_W - 1));
  assign w_word      = {r_shreg, w_bit};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !r_fault) w_next = S_WARMUP;
      end
      S_WARMUP: begin
        if (!start) begin
          w_next = S_IDLE;
        end else if (r_warm_cnt == WARM_W'(WARMUP_CYC - 1)) begin
          w_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // fault beats abort, abort beats a completing word
        if (w_fault_hit || !start) begin
          w_next = S_IDLE;
        end else if (w_word_done) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_valid && dout.data_ready) begin
          w_next = start ? S_COLLECT : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_warm_cnt <= '0;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
      r_rep_cnt  <= '0;
      r_last     <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ro_in};

      if (r_state == S_WARMUP) begin
        r_warm_cnt <= r_warm_cnt + WARM_W'(1);
      end else begin
        r_warm_cnt <= '0;
      end

      // the divider only runs inside COLLECT, so every entry to COLLECT starts from 0
      if ((r_state == S_COLLECT) && (w_next == S_COLLECT)) begin
        r_div <= w_strobe ? '0 : r_div + DIV_W'(1);
      end else begin
        r_div <= '0;
      end

      if ((r_state != S_COLLECT) || (w_next == S_IDLE)) begin
        r_bit_cnt <= '0;
        r_shreg   <= '0;
      end else if (w_accept) begin
        r_shreg   <= w_word[WORD_W-2:0];
        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + BIT_W'(1);
      end

      if (w_fault_hit) begin
        r_valid <= 1'b0;
      end else if ((r_state == S_COLLECT) && (w_next == S_HOLD)) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && dout.data_ready) begin
        r_valid <= 1'b0;
      end

      if (w_fault_hit) begin
        r_fault <= 1'b1;
      end

      if (r_state == S_WARMUP) begin
        r_rep_cnt <= '0;
      end else if (w_strobe) begin
        r_rep_cnt <= w_rep_next;
        r_last    <= w_raw;
      end
    end
  end

  assign ro_activate     = (r_state != S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign fault           = r_fault;
  assign dout.data_out   = r_data;
  assign dout.data_valid = r_valid;
endmodule
